emif_cal_bus_responder: RTL and testbench

Avalon responder for the 20-bit EMIF calibration bus driven by the hard sequencer's `uc_*` master port, for the ASE DDR4 device model. It terminates `cal_bus_avl_*` traffic with a word-addressed register file and a console sink at 0x1_0000. The console sink unpacks sequencer debug strings into a byte stream so the testbench or host side of the model can print them. The block sits beside the io_aux wrapper, on the slave side of the same bus.

---
 rtl/emif_cal_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_emif_cal_bus_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/emif_cal_bus_responder.sv
// emif_cal_bus_responder: Avalon slave for the 20-bit EMIF calibration bus.
// Word-addressed register file at address[19:16]==0 and a console sink at
// 0x1_0000 (data) / 0x1_0001 (status). The console FIFO and its unpacker are
// built only when the macro CAL_BUS_CONSOLE_EN is defined; otherwise the
// con_* outputs are tied low and the console addresses decode as unmapped.
module emif_cal_bus_responder #(
  parameter int REG_WORDS      = 64,
  parameter int CON_FIFO_DEPTH = 64
) (
  input  logic        cal_bus_clk,
  input  logic        cal_bus_reset,
  input  logic        cal_bus_avl_read,
  input  logic        cal_bus_avl_write,
  input  logic [19:0] cal_bus_avl_address,
  input  logic [31:0] cal_bus_avl_write_data,
  output logic [31:0] cal_bus_avl_read_data,
  output logic [31:0] cal_status,
  output logic [7:0]  con_data,
  output logic        con_eol,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        con_overflow
);

  localparam int RW = $clog2(REG_WORDS);

  logic [31:0]   r_regFile [REG_WORDS];
  logic [31:0]   r_readData;
  logic [31:0]   w_readValue;
  logic          w_isReg;
  logic [RW-1:0] w_regIdx;
  logic          w_statusHit;
  logic [31:0]   w_statusWord;

  assign w_isReg  = (cal_bus_avl_address[19:16] == 4'h0);
  assign w_regIdx = cal_bus_avl_address[RW-1:0];

  // Register file: full-word writes, upper index bits ignored so the space aliases
  always_ff @(posedge cal_bus_clk) begin
    if (cal_bus_reset) begin
      for (int i = 0; i < REG_WORDS; i++) r_regFile[i] <= '0;
    end else if (cal_bus_avl_write && w_isReg) begin
      r_regFile[w_regIdx] <= cal_bus_avl_write_data;
    end
  end

  assign cal_status = r_regFile[0];

  // Read mux from current state, so a same-cycle write is not seen by the read
  always_comb begin
    w_readValue = '0;
    if (w_isReg) begin
      w_readValue = r_regFile[w_regIdx];
    end else if (w_statusHit) begin
      w_readValue = w_statusWord;
    end
  end

  // Registered read data, held until the next read strobe
  always_ff @(posedge cal_bus_clk) begin
    if (cal_bus_reset) begin
      r_readData <= '0;
    end else if (cal_bus_avl_read) begin
      r_readData <= w_readValue;
    end
  end

  assign cal_bus_avl_read_data = r_readData;

`ifdef CAL_BUS_CONSOLE_EN
  localparam int PW = $clog2(CON_FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [8:0]    r_fifoMem [CON_FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  logic          w_conWrite;
  logic          w_statusWrite;
  logic [2:0]    w_byteCount;
  logic          w_term;
  logic [2:0]    w_pushCount;
  logic [8:0]    w_entry [5];
  logic [LW-1:0] w_free;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  assign w_statusHit   = (cal_bus_avl_address == 20'h1_0001);
  assign w_conWrite    = cal_bus_avl_write && (cal_bus_avl_address == 20'h1_0000);
  assign w_statusWrite = cal_bus_avl_write && w_statusHit;
  assign w_statusWord  = {r_overflow, 15'b0, 16'(r_level)};

  // Unpack a console word LSB first up to the first zero byte; a zero adds a newline entry
  always_comb begin
    w_byteCount = '0;
    w_term      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_term) begin
        if (cal_bus_avl_write_data[8*k +: 8] == 8'h00) w_term = 1'b1;
        else w_byteCount = w_byteCount + 3'd1;
      end
    end
    w_pushCount = w_byteCount + {2'b00, w_term};
    for (int k = 0; k < 5; k++) w_entry[k] = {1'b1, 8'h0A};
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_byteCount) w_entry[k] = {1'b0, cal_bus_avl_write_data[8*k +: 8]};
    end
  end

  // Space check uses the level before any same-cycle pop; a word is all or nothing
  assign w_free = LW'(CON_FIFO_DEPTH) - r_level;
  assign w_drop = w_conWrite && (LW'(w_pushCount) > w_free);
  assign w_push = w_conWrite && !w_drop;
  assign w_pop  = (r_level != '0) && con_ready;

  // FIFO storage: all entries of an accepted word land in consecutive slots at once
  always_ff @(posedge cal_bus_clk) begin
    if (!cal_bus_reset && w_push) begin
      for (int k = 0; k < 5; k++) begin
        if (3'(k) < w_pushCount) r_fifoMem[r_wrPtr + PW'(k)] <= w_entry[k];
      end
    end
  end

  // FIFO pointers, level and sticky overflow; setting overflow beats clearing it
  always_ff @(posedge cal_bus_clk) begin
    if (cal_bus_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(w_pushCount);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_level <= r_level + (w_push ? LW'(w_pushCount) : LW'(0)) - (w_pop ? LW'(1) : LW'(0));
      if (w_drop) r_overflow <= 1'b1;
      else if (w_statusWrite && cal_bus_avl_write_data[0]) r_overflow <= 1'b0;
    end
  end

  assign con_valid    = (r_level != '0);
  assign con_data     = con_valid ? r_fifoMem[r_rdPtr][7:0] : 8'h00;
  assign con_eol      = con_valid ? r_fifoMem[r_rdPtr][8] : 1'b0;
  assign con_overflow = r_overflow;
`else
  logic w_unusedConsole;

  assign w_statusHit     = 1'b0;
  assign w_statusWord    = '0;
  assign con_valid       = 1'b0;
  assign con_data        = 8'h00;
  assign con_eol         = 1'b0;
  assign con_overflow    = 1'b0;
  assign w_unusedConsole = &{1'b0, con_ready, cal_bus_avl_address[15:0]};
`endif

endmodule

// File: tb/tb_emif_cal_bus_responder.sv
// Directed testbench for emif_cal_bus_responder (REG_WORDS=64, CON_FIFO_DEPTH=8).
// Console checks are compiled in when CAL_BUS_CONSOLE_EN is defined; otherwise
// the bench checks that the console outputs and addresses are inert.
module tb_emif_cal_bus_responder;

  logic        clk;
  logic        reset;
  logic        avlRead;
  logic        avlWrite;
  logic [19:0] avlAddress;
  logic [31:0] avlWriteData;
  logic [31:0] avlReadData;
  logic [31:0] calStatus;
  logic [7:0]  conData;
  logic        conEol;
  logic        conValid;
  logic        conReady;
  logic        conOverflow;

  int numChecks = 0;
  int numFail   = 0;

  emif_cal_bus_responder #(
    .REG_WORDS      (64),
    .CON_FIFO_DEPTH (8)
  ) dut (
    .cal_bus_clk            (clk),
    .cal_bus_reset          (reset),
    .cal_bus_avl_read       (avlRead),
    .cal_bus_avl_write      (avlWrite),
    .cal_bus_avl_address    (avlAddress),
    .cal_bus_avl_write_data (avlWriteData),
    .cal_bus_avl_read_data  (avlReadData),
    .cal_status             (calStatus),
    .con_data               (conData),
    .con_eol                (conEol),
    .con_valid              (conValid),
    .con_ready              (conReady),
    .con_overflow           (conOverflow)
  );

  // Free-running 100 MHz clock; inputs change and outputs are sampled on the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle across exactly one rising edge, then return the strobes to idle
  task automatic applyStimulus(input logic rd, input logic wr, input logic [19:0] addr,
                               input logic [31:0] data, input logic rdy);
    avlRead      = rd;
    avlWrite     = wr;
    avlAddress   = addr;
    avlWriteData = data;
    conReady     = rdy;
    @(negedge clk);
    avlRead  = 1'b0;
    avlWrite = 1'b0;
    conReady = 1'b0;
  endtask

  // One comparison: count it, and report tag/observed/expected when it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed sequence: reset, register path, console (or its absence), reset mid-stream
  initial begin
    reset        = 1'b1;
    avlRead      = 1'b0;
    avlWrite     = 1'b0;
    avlAddress   = '0;
    avlWriteData = '0;
    conReady     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_read_data", avlReadData, 32'h0);
    checkOutput("rst_cal_status", calStatus, 32'h0);
    checkOutput("rst_con_valid", {31'b0, conValid}, 32'h0);
    checkOutput("rst_con_data", {24'b0, conData}, 32'h0);
    checkOutput("rst_con_eol", {31'b0, conEol}, 32'h0);
    checkOutput("rst_con_overflow", {31'b0, conOverflow}, 32'h0);

    // Register path, aliasing, status mirror, read-before-write, unmapped space
    applyStimulus(0, 1, 20'h0_0005, 32'hCAFE_F00D, 0);
    applyStimulus(1, 0, 20'h0_0005, 32'h0, 0);
    checkOutput("reg5_read", avlReadData, 32'hCAFE_F00D);
    applyStimulus(1, 0, 20'h0_0045, 32'h0, 0);
    checkOutput("reg45_alias", avlReadData, 32'hCAFE_F00D);
    applyStimulus(0, 1, 20'h0_0000, 32'h1234_5678, 0);
    checkOutput("cal_status_word0", calStatus, 32'h1234_5678);
    applyStimulus(1, 1, 20'h0_0005, 32'hDEAD_BEEF, 0);
    checkOutput("rw_same_cycle_old", avlReadData, 32'hCAFE_F00D);
    applyStimulus(1, 0, 20'h0_0005, 32'h0, 0);
    checkOutput("rw_same_cycle_new", avlReadData, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 20'h2_0005, 32'h5555_AAAA, 0);
    applyStimulus(1, 0, 20'h2_0005, 32'h0, 0);
    checkOutput("unmapped_read", avlReadData, 32'h0);
    applyStimulus(0, 0, 20'h0, 32'h0, 0);
    checkOutput("read_data_hold", avlReadData, 32'h0);
    applyStimulus(1, 0, 20'h0_0005, 32'h0, 0);
    checkOutput("unmapped_write_ignored", avlReadData, 32'hDEAD_BEEF);

`ifdef CAL_BUS_CONSOLE_EN
    // Console string "Hello" followed by a newline entry
    applyStimulus(0, 1, 20'h1_0000, 32'h6C6C_6548, 0);
    checkOutput("hello_valid", {31'b0, conValid}, 32'h1);
    checkOutput("hello_first", {24'b0, conData}, 32'h48);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("hello_level4", avlReadData, 32'h0000_0004);
    applyStimulus(0, 1, 20'h1_0000, 32'h0000_006F, 0);
    applyStimulus(1, 0, 20'h1_0000, 32'h0, 0);
    checkOutput("con_data_read_zero", avlReadData, 32'h0);
    begin
      logic [8:0] expStream [6];
      expStream[0] = 9'h048; expStream[1] = 9'h065; expStream[2] = 9'h06C;
      expStream[3] = 9'h06C; expStream[4] = 9'h06F; expStream[5] = 9'h10A;
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("hello_entry%0d", i), {22'b0, conValid, conEol, conData},
                    {22'b0, 1'b1, expStream[i]});
        applyStimulus(0, 0, 20'h0, 32'h0, 1);
      end
    end
    checkOutput("hello_drained_valid", {31'b0, conValid}, 32'h0);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("hello_level0", avlReadData, 32'h0);

    // Leading zero byte: only the newline entry, later bytes discarded
    applyStimulus(0, 1, 20'h1_0000, 32'h4100_0000, 0);
    checkOutput("empty_term_entry", {22'b0, conValid, conEol, conData}, {22'b0, 1'b1, 9'h10A});
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("empty_term_level1", avlReadData, 32'h0000_0001);
    applyStimulus(0, 0, 20'h0, 32'h0, 1);
    checkOutput("empty_term_drained", {31'b0, conValid}, 32'h0);

    // Fill to exactly full, then drop a word and clear the sticky flag
    applyStimulus(0, 1, 20'h1_0000, 32'h6463_6261, 0);
    applyStimulus(0, 1, 20'h1_0000, 32'h6463_6261, 0);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("full_level8", avlReadData, 32'h0000_0008);
    checkOutput("full_no_overflow", {31'b0, conOverflow}, 32'h0);
    applyStimulus(0, 1, 20'h1_0000, 32'h6463_6261, 0);
    checkOutput("drop_overflow", {31'b0, conOverflow}, 32'h1);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("drop_status", avlReadData, 32'h8000_0008);
    checkOutput("full_head", {22'b0, conValid, conEol, conData}, {22'b0, 1'b1, 9'h061});
    applyStimulus(0, 1, 20'h1_0001, 32'h0000_0001, 0);
    checkOutput("overflow_cleared", {31'b0, conOverflow}, 32'h0);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("cleared_status", avlReadData, 32'h0000_0008);

    // Full FIFO with a pop in the same cycle still drops the word
    applyStimulus(0, 1, 20'h1_0000, 32'h0000_0041, 1);
    checkOutput("pushpop_overflow", {31'b0, conOverflow}, 32'h1);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("pushpop_status", avlReadData, 32'h8000_0007);
    checkOutput("pushpop_head", {24'b0, conData}, 32'h62);
    applyStimulus(0, 1, 20'h1_0001, 32'h0000_0002, 0);
    checkOutput("clear_bit0_only", {31'b0, conOverflow}, 32'h1);
    applyStimulus(0, 1, 20'h1_0001, 32'h0000_0001, 0);
    checkOutput("clear_again", {31'b0, conOverflow}, 32'h0);

    // Leave five entries queued ahead of the reset
    applyStimulus(0, 0, 20'h0, 32'h0, 1);
    applyStimulus(0, 0, 20'h0, 32'h0, 1);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("pre_reset_level5", avlReadData, 32'h0000_0005);
    checkOutput("pre_reset_head", {24'b0, conData}, 32'h64);
`else
    // Console built out: its addresses and outputs stay inert
    applyStimulus(0, 1, 20'h1_0000, 32'h6C6C_6548, 0);
    checkOutput("nocon_valid", {31'b0, conValid}, 32'h0);
    checkOutput("nocon_data", {24'b0, conData}, 32'h0);
    checkOutput("nocon_status_mirror", calStatus, 32'h1234_5678);
    applyStimulus(0, 1, 20'h1_0000, 32'h6463_6261, 0);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("nocon_status_read", avlReadData, 32'h0);
    checkOutput("nocon_overflow", {31'b0, conOverflow}, 32'h0);
    applyStimulus(1, 0, 20'h0_0005, 32'h0, 0);
    checkOutput("pre_reset_read", avlReadData, 32'hDEAD_BEEF);
`endif

    // Reset mid-stream together with a read of word 0: everything returns to reset values
    reset = 1'b1;
    applyStimulus(1, 0, 20'h0_0000, 32'h0, 0);
    reset = 1'b0;
    checkOutput("midrst_read_data", avlReadData, 32'h0);
    checkOutput("midrst_cal_status", calStatus, 32'h0);
    checkOutput("midrst_con_valid", {31'b0, conValid}, 32'h0);
    checkOutput("midrst_con_data", {24'b0, conData}, 32'h0);
    applyStimulus(1, 0, 20'h1_0001, 32'h0, 0);
    checkOutput("midrst_level0", avlReadData, 32'h0);
    applyStimulus(1, 0, 20'h0_0005, 32'h0, 0);
    checkOutput("midrst_reg5", avlReadData, 32'h0);
    applyStimulus(1, 0, 20'h0_0000, 32'h0, 0);
    checkOutput("midrst_reg0", avlReadData, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
    $finish;
  end

endmodule
